// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer slice.
//   - ALU field widths and the 16-bit command packing {opcode, operad, rd_reg1, rd_reg2}
//   - opcode constants
//   - FSM state encoding
package alu_cmd_sequencer_pkg;

    localparam int OPC_W = 3;
    localparam int OPD_W = 5;
    localparam int REG_W = 4;
    localparam int RES_W = 4;
    localparam int CMD_W = OPC_W + OPD_W + 2 * REG_W;

    localparam logic [OPC_W-1:0] OP_ADD = 3'd0;

    // Field order here is the packing order; the first member is the MSB field.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OPD_W-1:0] operad;
        logic [REG_W-1:0] rd_reg1;
        logic [REG_W-1:0] rd_reg2;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle around the sequencer: host command channel, registered ALU
// drive plus the ALU result, and the valid/ready result channel.
//   slave  : the sequencer's view (accepts commands, drives the ALU, offers results)
//   master : the environment's view (host, ALU instance and result consumer)
interface alu_cmd_sequencer_if;
    import alu_cmd_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPC_W-1:0] cmd_opcode;
    logic [OPD_W-1:0] cmd_operad;
    logic [REG_W-1:0] cmd_rd_reg1;
    logic [REG_W-1:0] cmd_rd_reg2;

    logic [OPC_W-1:0] alu_opcode;
    logic [OPD_W-1:0] alu_operad;
    logic [REG_W-1:0] alu_rd_reg1;
    logic [REG_W-1:0] alu_rd_reg2;
    logic [RES_W-1:0] alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_operad, cmd_rd_reg1, cmd_rd_reg2,
        output cmd_ready,
        output alu_opcode, alu_operad, alu_rd_reg1, alu_rd_reg2,
        input  alu_result,
        output res_valid, res_data,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_operad, cmd_rd_reg1, cmd_rd_reg2,
        input  cmd_ready,
        input  alu_opcode, alu_operad, alu_rd_reg1, alu_rd_reg2,
        output alu_result,
        input  res_valid, res_data,
        output res_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x alu_cmd_t, show-ahead read (rd_data is the head).
//   clk, rst      : clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data : write request / data; ignored when full
//   pop, rd_data  : read request / head entry; pop ignored when empty
//   full, empty   : status from (log2(DEPTH)+1)-bit pointers
module alu_cmd_fifo
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  alu_cmd_t wr_data,
    input  logic     pop,
    output alu_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    alu_cmd_t    mem [DEPTH];

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // differing only in the wrap bit mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of process ordering.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers define validity,
    // and a reset on the array would turn it into flops with a reset tree.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU command interface. Queues host commands, issues
// them to the ALU one at a time, waits ALU_LAT edges, captures the result and
// holds it on a valid/ready port until consumed.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : alu_cmd_sequencer_if.slave (command, ALU drive, result channels)
//   busy        : FSM not idle or commands still queued
//   issued_cnt  : commands issued to the ALU since reset, wraps silently
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int CNTW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic                busy,
    output logic [CNTW-1:0]     issued_cnt
);

    localparam int CW = $clog2(ALU_LAT + 1);

    seq_state_e       state_q, state_d;
    logic             pop;
    logic             capture;
    logic             fifo_full, fifo_empty;
    alu_cmd_t         cmd_in, fifo_head, alu_q;
    logic [CW-1:0]    cnt_q;
    logic [RES_W-1:0] res_q;
    logic [CNTW-1:0]  issued_q;

    assign cmd_in = '{opcode:  bus.cmd_opcode,  operad:  bus.cmd_operad,
                      rd_reg1: bus.cmd_rd_reg1, rd_reg2: bus.cmd_rd_reg2};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.cmd_valid),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Readiness depends on fullness only, so a full FIFO refuses even in a pop cycle.
    assign bus.cmd_ready = !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Consuming the result and issuing the next command share an edge.
                if (bus.res_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ALU drive registers keep the last issued command until the next pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            issued_q <= '0;
        end else begin
            if (pop) begin
                alu_q    <= fifo_head;
                cnt_q    <= CW'(ALU_LAT);
                issued_q <= issued_q + 1'b1;
            end else if (state_q == S_WAIT) begin
                cnt_q    <= cnt_q - 1'b1;
            end
            if (capture) res_q <= bus.alu_result;
        end
    end

    assign bus.alu_opcode  = alu_q.opcode;
    assign bus.alu_operad  = alu_q.operad;
    assign bus.alu_rd_reg1 = alu_q.rd_reg1;
    assign bus.alu_rd_reg2 = alu_q.rd_reg2;

    // A result is held exactly while in HOLD.
    assign bus.res_valid = (state_q == S_HOLD);
    assign bus.res_data  = res_q;

    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign issued_cnt = issued_q;

endmodule
